debounce_sched: RTL and testbench

Time-multiplexed debouncer and event arbiter for the TapTempo button inputs. It holds per-button debounce state for NB channels and services one channel per `tp_i` timepulse in round-robin slot order. Debounced press and release transitions are posted as events to a single valid/ready consumer port, with round-robin grant among pending channels. It sits between the input synchronizers and the tempo-measurement logic, and replaces one debouncer instance per button.

---
 rtl/debounce_sched.sv | 183 ++++++++++++++++++
 tb/tb_debounce_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_sched.sv
// Time-multiplexed button debouncer: one channel serviced per timepulse in slot order,
// debounced transitions posted to a round-robin arbitrated valid/ready event port.
module debounce_sched #(
  parameter int unsigned NB        = 4,
  parameter int unsigned MAX_COUNT = 4096,
  parameter int unsigned IDW       = $clog2(NB)
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           tp_i,
  input  logic [NB-1:0]  btn_i,
  output logic [NB-1:0]  btn_o,
  output logic           evt_valid_o,
  output logic [IDW-1:0] evt_id_o,
  output logic           evt_press_o,
  input  logic           evt_ready_i,
  output logic           ovf_o
);

  localparam int unsigned CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);

  typedef enum logic [1:0] {
    WAIT_LOW,
    CNT_HIGH,
    WAIT_HIGH,
    CNT_LOW
  } state_t;

  state_t         st_q  [NB];
  state_t         st_d  [NB];
  logic [CW-1:0]  cnt_q [NB];
  logic [CW-1:0]  cnt_d [NB];
  logic [IDW-1:0] slot_q, slot_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [NB-1:0]  pend_q, pend_d;
  logic [NB-1:0]  kind_q, kind_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic           press_q, press_d;
  logic           ovf_q, ovf_d;

  logic           post;
  logic           post_kind;
  logic           load;
  logic           gnt_found;
  logic [IDW-1:0] gnt_id;

  // Modular add for channel indices; NB need not be a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NB) s = s - NB;
    return IDW'(s);
  endfunction

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    post      = 1'b0;
    post_kind = 1'b0;
    if (tp_i) begin
      slot_d = wrap_add(slot_q, 1);
      case (st_q[slot_q])
        WAIT_LOW: begin
          if (btn_i[slot_q]) begin
            st_d[slot_q]  = CNT_HIGH;
            cnt_d[slot_q] = '0;
            post          = 1'b1;
            post_kind     = 1'b1;
          end
        end
        CNT_HIGH: begin
          if (cnt_q[slot_q] == CNT_LAST) begin
            st_d[slot_q]  = WAIT_HIGH;
            cnt_d[slot_q] = '0;
          end else begin
            cnt_d[slot_q] = cnt_q[slot_q] + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!btn_i[slot_q]) begin
            st_d[slot_q]  = CNT_LOW;
            cnt_d[slot_q] = '0;
            post          = 1'b1;
            post_kind     = 1'b0;
          end
        end
        CNT_LOW: begin
          if (cnt_q[slot_q] == CNT_LAST) begin
            st_d[slot_q]  = WAIT_LOW;
            cnt_d[slot_q] = '0;
          end else begin
            cnt_d[slot_q] = cnt_q[slot_q] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (!gnt_found && pend_q[wrap_add(rr_q, i)]) begin
        gnt_found = 1'b1;
        gnt_id    = wrap_add(rr_q, i);
      end
    end
  end

  // Grant reads the registered pending set, so a post on the granted channel
  // lands after the clear and stays pending with its new kind.
  always_comb begin
    load    = !valid_q || evt_ready_i;
    pend_d  = pend_q;
    kind_d  = kind_q;
    valid_d = valid_q;
    id_d    = id_q;
    press_d = press_q;
    rr_d    = rr_q;
    ovf_d   = 1'b0;
    if (load) begin
      if (gnt_found) begin
        valid_d        = 1'b1;
        id_d           = gnt_id;
        press_d        = kind_q[gnt_id];
        pend_d[gnt_id] = 1'b0;
        rr_d           = wrap_add(gnt_id, 1);
      end else begin
        valid_d = 1'b0;
      end
    end
    if (post) begin
      ovf_d          = pend_q[slot_q] && !(load && gnt_found && (gnt_id == slot_q));
      pend_d[slot_q] = 1'b1;
      kind_d[slot_q] = post_kind;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 0; k < NB; k++) begin
        st_q[k]  <= WAIT_LOW;
        cnt_q[k] <= '0;
      end
      slot_q  <= '0;
      rr_q    <= '0;
      pend_q  <= '0;
      kind_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      press_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      kind_q  <= kind_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      press_q <= press_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    btn_o = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      btn_o[k] = (st_q[k] == CNT_HIGH) || (st_q[k] == WAIT_HIGH);
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_id_o    = id_q;
  assign evt_press_o = press_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_debounce_sched.sv
// Scoreboard bench for debounce_sched: a level/lockout reference model queues expected
// events; a negedge monitor compares levels, overflow, valid and delivered events.
module tb_debounce_sched;
  localparam int unsigned NB  = 4;
  localparam int unsigned MC  = 4;
  localparam int unsigned IDW = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           tp    = 1'b0;
  logic           rdy   = 1'b0;
  logic [NB-1:0]  btn   = '0;
  logic [NB-1:0]  btn_o;
  logic           evt_valid_o;
  logic [IDW-1:0] evt_id_o;
  logic           evt_press_o;
  logic           ovf_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    bit press;
  } evt_t;
  evt_t expq[$];

  // Reference model: debounced level plus remaining lockout services per channel.
  logic [NB-1:0] lvl, mpend, mkind;
  int  lock [NB];
  int  mslot, mrr, g, ch;
  bit  mvalid, movf, acc, post, pk;

  debounce_sched #(.NB(NB), .MAX_COUNT(MC), .IDW(IDW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .tp_i        (tp),
    .btn_i       (btn),
    .btn_o       (btn_o),
    .evt_valid_o (evt_valid_o),
    .evt_id_o    (evt_id_o),
    .evt_press_o (evt_press_o),
    .evt_ready_i (rdy),
    .ovf_o       (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl = '0; mpend = '0; mkind = '0;
      for (int k = 0; k < NB; k++) lock[k] = 0;
      mslot = 0; mrr = 0; mvalid = 0; movf = 0;
      expq.delete();
    end else begin
      post = 0; pk = 0; ch = mslot;
      if (tp) begin
        if (lock[ch] > 0) lock[ch]--;
        else if (btn[ch] != lvl[ch]) begin
          lvl[ch] = btn[ch]; lock[ch] = MC; post = 1; pk = btn[ch];
        end
        mslot = (mslot + 1) % NB;
      end
      acc = mvalid && rdy;
      g = -1;
      if (!mvalid || acc) begin
        for (int i = 0; i < NB; i++)
          if (g < 0 && mpend[(mrr + i) % NB]) g = (mrr + i) % NB;
        if (g >= 0) begin
          expq.push_back('{g, mkind[g]});
          mvalid = 1;
          mrr = (g + 1) % NB;
        end else mvalid = 0;
      end
      movf = post && mpend[ch] && (g != ch);
      if (g >= 0) mpend[g] = 1'b0;
      if (post) begin mpend[ch] = 1'b1; mkind[ch] = pk; end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("btn_o", btn_o, lvl);
      chk("evt_valid", evt_valid_o, mvalid);
      chk("ovf", ovf_o, movf);
      if (evt_valid_o) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL evt_unexpected act id=%0d exp=none at %0t", evt_id_o, $time);
        end else begin
          chk("evt_id", evt_id_o, expq[0].id);
          chk("evt_press", evt_press_o, expq[0].press);
          if (rdy) void'(expq.pop_front());
        end
      end
    end
  end

  task automatic step(input logic t, input logic [NB-1:0] b, input logic r);
    tp = t; btn = b; rdy = r;
    @(posedge clk); #1;
  endtask

  task automatic run(input int n, input int div, input logic [NB-1:0] b, input logic r);
    for (int i = 0; i < n; i++) step((i % div) == div - 1, b, r);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_btn"}, btn_o, 0);
    chk({nm, "_valid"}, evt_valid_o, 0);
    chk({nm, "_id"}, evt_id_o, 0);
    chk({nm, "_press"}, evt_press_o, 0);
    chk({nm, "_ovf"}, ovf_o, 0);
  endtask

  initial begin
    logic [NB-1:0] b;
    #12;
    chk_outputs_zero("reset_init");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clean press and release on channel 2.
    run(24, 4, 4'b0100, 1'b1);
    run(80, 4, 4'b0000, 1'b1);

    // Bounce on channel 1 after a press.
    run(16, 4, 4'b0010, 1'b1);
    for (int i = 0; i < 40; i++) begin
      b = '0; b[1] = 1'($urandom % 2);
      run(4, 4, b, 1'b1);
    end
    run(100, 4, 4'b0000, 1'b1);

    // Simultaneous presses with a stalled consumer.
    run(40, 4, 4'b1111, 1'b0);
    run(12, 4, 4'b1111, 1'b1);
    run(100, 4, 4'b0000, 1'b1);

    // Overwrite on channel 3: press, release, press while stalled.
    run(80, 4, 4'b1000, 1'b0);
    run(80, 4, 4'b0000, 1'b0);
    run(80, 4, 4'b1000, 1'b0);
    run(20, 4, 4'b1000, 1'b1);
    run(100, 4, 4'b0000, 1'b1);

    // Round robin between continuously toggling channels 0 and 1.
    for (int i = 0; i < 200; i++) begin
      b = '0; b[1:0] = 2'($urandom);
      step(1'b1, b, i >= 12);
    end
    run(40, 1, 4'b0000, 1'b1);

    // Reset mid-run with events queued.
    run(30, 4, 4'b1111, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("reset_mid");
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    rst_n = 1'b1;
    run(4, 4, 4'b1111, 1'b1);
    chk("post_reset_slot0", btn_o, 4'b0001);
    run(100, 4, 4'b0000, 1'b1);

    // Random traffic.
    b = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NB; k++) if ($urandom % 8 == 0) b[k] = ~b[k];
      step(($urandom % 3) == 0, b, ($urandom % 10) < 7);
    end

    run(200, 1, 4'b0000, 1'b1);
    chk("drain_queue_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
